// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1/8E1/8O1/8N2, LSB first) fed by a small valid/ready byte FIFO.
// Each byte is latched at pop, so FIFO traffic never disturbs the frame on the line.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLoad = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]      idx_q, idx_d;
    logic            stop_idx_q, stop_idx_d;
    logic [7:0]      byte_q, byte_d;
    logic            tx_q, tx_d;
    logic            push, pop, bit_end, last_stop;

    assign in_ready  = (count_q != CntFull);
    assign busy      = (state_q != StIdle) || (count_q != '0);
    assign tx        = tx_q;
    assign push      = in_valid && in_ready;
    assign bit_end   = (baud_q == '0);
    assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
    // Pop from IDLE, or back-to-back at the end of the last stop bit.
    assign pop = (count_q != '0) &&
                 ((state_q == StIdle) || (state_q == StStop && bit_end && last_stop));

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = bit_end ? BaudLoad : baud_q - 1'b1;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        byte_d     = byte_q;
        tx_d       = tx_q;
        case (state_q)
            StIdle: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (pop) begin
                    byte_d  = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = BaudLoad;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    tx_d    = byte_q[0];
                    idx_d   = 3'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        stop_idx_d = 1'b0;
                        if (PARITY != 0) begin
                            state_d = StParity;
                            tx_d    = (PARITY == 2) ? ~^byte_q : ^byte_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = byte_q[idx_q + 3'd1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d    = StStop;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (!last_stop) begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end else if (pop) begin
                        byte_d  = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            baud_q     <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            byte_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            byte_q     <= byte_d;
            tx_q       <= tx_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
